psychogenic_sar_sched: RTL and testbench
========================================

# psychogenic_sar_sched

Round-robin scheduler and SAR sequencer for the shared analog measurement path on the `ua` pins, consisting of an analog input mux, a capacitive DAC and a comparator. It arbitrates between NREQ digital requesters and grants one channel at a time. For the granted channel it enables the mux, runs a binary-search conversion by driving the DAC code and sampling the comparator, then returns the result with a one-cycle done/ack. It sits between the tile's digital control logic and the analog macro.

## Interface
Parameters:
- NREQ, 4: number of requesters/analog channels (2..8)
- NBITS, 8: conversion resolution
- ACQ, 4: acquisition cycles with mux enabled before first trial (≥1)
- SETTLE, 3: cycles per trial between DAC update and comparator sample (≥3; covers 2-flop sync)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  level request per channel; held until ack
- ack  out  NREQ  one-hot, one-cycle pulse with done
- busy  out  1  high from grant through DONE
- mux_en  out  1  analog mux enable
- mux_sel  out  $clog2(NREQ)  granted channel
- dac_code  out  NBITS  DAC trial code
- cmp_in  in  1  raw comparator output, async; 1 = input ≥ DAC
- done  out  1  one-cycle conversion-complete pulse
- result  out  NBITS  last result; holds until next done
- result_chan  out  $clog2(NREQ)  channel of `result`

## Operation
- The FSM has five states: IDLE, ACQUIRE, TRIAL, DECIDE, DONE.
- IDLE transitions:
  - If any req is high, grant the round-robin winner and go to ACQUIRE.
  - The search starts at last_grant+1 and wraps modulo NREQ. last_grant resets to NREQ-1, so channel 0 wins first.
  - The grant latches the channel into mux_sel and sets mux_en=1. req is sampled only in IDLE.
- ACQUIRE: count ACQ cycles, then go to TRIAL with bit index = NBITS-1.
- TRIAL:
  - On entry, dac_code = partial | (1<<bit).
  - Hold for SETTLE cycles, then go to DECIDE.
- DECIDE (1 cycle):
  - If cmp_sync=1, keep the bit; otherwise clear it in partial.
  - If bit=0, go to DONE; otherwise decrement bit and go to TRIAL.
- DONE (1 cycle):
  - result = partial, result_chan = mux_sel, done=1, ack[mux_sel]=1.
  - mux_en=0, dac_code=0, then go to IDLE.
- cmp_in passes through a 2-flop synchronizer (cmp_sync) that is always running.
- A req dropped mid-conversion does not abort: the conversion completes and ack still pulses. Requests arriving while busy wait for IDLE.
- No zero-cycle idle: at least one IDLE cycle separates conversions. If req is still held after ack, the channel competes again on the next IDLE cycle.
- Reset values: all outputs 0, state=IDLE, partial=0, sync flops 0. A reset mid-conversion aborts immediately with no done or ack, and result/result_chan clear to 0.

## Timing
- Cycle 0 is IDLE sampling req.
- mux_en/mux_sel are valid from cycle 1.
- First dac_code is valid at cycle 1+ACQ.
- Each bit takes SETTLE+1 cycles.
- done/ack are high at cycle ACQ + NBITS·(SETTLE+1) + 1. With defaults this is cycle 37.
- busy is high for cycles 1..37. busy, mux_en, dac_code and done are all registered outputs.
- Within a trial, cmp_sync sampled in DECIDE reflects cmp_in from SETTLE-2 cycles after the dac_code update.

## Structure
- Package psychogenic_sar_pkg holds:
  - the state enum (IDLE, ACQUIRE, TRIAL, DECIDE, DONE)
  - default parameter constants
  - a localparam function for the counter width $clog2(max(ACQ, SETTLE)+1)
- One sub-module: psychogenic_rr_arb. It is combinational, with inputs req and last_grant and outputs gnt_valid and gnt_idx. The last_grant register lives in the parent.
- Single shared down-counter for ACQ and SETTLE.

## Test plan
- req=4'b0001, comparator model cmp_in=(0xA5 ≥ dac_code) → done at cycle 37, result=0xA5, result_chan=0, ack=4'b0001, trial codes 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
- cmp_in tied 1 → result=0xFF. cmp_in tied 0 → result=0x00. In both cases dac_code=0 and mux_en=0 after done.
- req=4'b1111 held continuously → grant order 0,1,2,3,0. Each ack is one cycle. Exactly one IDLE cycle between conversions.
- Channel 2 is busy, req[1] rises at cycle 10 → no effect until IDLE. Channel 1 is granted next, then channel 3 if pending, before wrapping.
- rst at cycle 20 of a conversion → next cycle: all outputs 0, no done, state IDLE. A following req=4'b0010 is granted normally, and channel 0 still has priority if also requesting.
- req[0] dropped at cycle 5 mid-conversion → conversion completes, done and ack[0] pulse at cycle 37, result valid.

Source files
------------

// File: rtl/psychogenic_sar_sched_pkg.sv
// Shared types and constants for the SAR scheduler: FSM state encoding,
// default parameters and the shared counter width helper.
package psychogenic_sar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    TRIAL,
    DECIDE,
    DONE
  } state_e;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_NBITS  = 8;
  localparam int DEF_ACQ    = 4;
  localparam int DEF_SETTLE = 3;

  // One down-counter serves both acquisition and settle phases.
  function automatic int cnt_w(input int acq, input int settle);
    int m;
    m = (acq > settle) ? acq : settle;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/psychogenic_sar_sched_if.sv
// Requester-side bus of the SAR scheduler: level requests in, ack/done/result out.
interface psychogenic_sar_sched_if
  import psychogenic_sar_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int NBITS = DEF_NBITS
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         ack;
  logic                    busy;
  logic                    done;
  logic [NBITS-1:0]        result;
  logic [$clog2(NREQ)-1:0] result_chan;

  modport master (output req, input ack, busy, done, result, result_chan);
  modport slave  (input req, output ack, busy, done, result, result_chan);
endinterface

// File: rtl/psychogenic_sar_sched_rr_arb.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module psychogenic_rr_arb
  import psychogenic_sar_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int SW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   last_grant,
  output logic            gnt_valid,
  output logic [SW-1:0]   gnt_idx
);

  logic [SW:0]   sum;
  logic [SW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int i = NREQ; i >= 1; i--) begin
      sum = {1'b0, last_grant} + (SW+1)'(i);
      if (sum >= (SW+1)'(NREQ)) sum = sum - (SW+1)'(NREQ);
      idx = sum[SW-1:0];
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/psychogenic_sar_sched.sv
// Round-robin scheduler plus SAR sequencer driving the shared mux/DAC/comparator
// path; one channel converted at a time, result returned with a done/ack pulse.
module psychogenic_sar_sched
  import psychogenic_sar_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int NBITS  = DEF_NBITS,
  parameter int ACQ    = DEF_ACQ,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                    clk,
  input  logic                    rst,
  psychogenic_sar_sched_if.slave  bus,
  output logic                    mux_en,
  output logic [$clog2(NREQ)-1:0] mux_sel,
  output logic [NBITS-1:0]        dac_code,
  input  logic                    cmp_in
);

  localparam int SW = $clog2(NREQ);
  localparam int CW = cnt_w(ACQ, SETTLE);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [NBITS-1:0] partial, bit_mask, next_partial;
  logic [SW-1:0]    last_grant, gnt_idx;
  logic             gnt_valid;
  logic [1:0]       cmp_ff;
  logic             cmp_sync;
  logic [NREQ-1:0]  ack_q, ack_onehot;
  logic             busy_q, done_q;
  logic [NBITS-1:0] result_q;
  logic [SW-1:0]    result_chan_q;

  psychogenic_rr_arb #(.NREQ(NREQ)) u_arb (
    .req        (bus.req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign cmp_sync = cmp_ff[1];

  always_comb begin
    bit_mask          = '0;
    bit_mask[bit_idx] = 1'b1;
    next_partial      = cmp_sync ? (partial | bit_mask) : (partial & ~bit_mask);
    ack_onehot          = '0;
    ack_onehot[mux_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      partial       <= '0;
      last_grant    <= SW'(NREQ - 1);
      cmp_ff        <= '0;
      mux_en        <= 1'b0;
      mux_sel       <= '0;
      dac_code      <= '0;
      ack_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      result_chan_q <= '0;
    end else begin
      cmp_ff <= {cmp_ff[0], cmp_in};
      done_q <= 1'b0;
      ack_q  <= '0;
      case (state)
        IDLE: if (gnt_valid) begin
          state      <= ACQUIRE;
          mux_sel    <= gnt_idx;
          last_grant <= gnt_idx;
          mux_en     <= 1'b1;
          busy_q     <= 1'b1;
          partial    <= '0;
          cnt        <= CW'(ACQ - 1);
        end
        ACQUIRE: begin
          if (cnt == '0) begin
            state    <= TRIAL;
            bit_idx  <= BW'(NBITS - 1);
            dac_code <= {1'b1, {(NBITS-1){1'b0}}};
            cnt      <= CW'(SETTLE - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TRIAL: begin
          if (cnt == '0) state <= DECIDE;
          else           cnt   <= cnt - 1'b1;
        end
        DECIDE: begin
          partial <= next_partial;
          // Result and pulses are registered here so they appear with DONE.
          if (bit_idx == '0) begin
            state         <= DONE;
            done_q        <= 1'b1;
            ack_q         <= ack_onehot;
            result_q      <= next_partial;
            result_chan_q <= mux_sel;
          end else begin
            state    <= TRIAL;
            bit_idx  <= bit_idx - 1'b1;
            dac_code <= next_partial | (bit_mask >> 1);
            cnt      <= CW'(SETTLE - 1);
          end
        end
        DONE: begin
          state    <= IDLE;
          mux_en   <= 1'b0;
          dac_code <= '0;
          busy_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.result_chan = result_chan_q;

endmodule

// File: tb/tb_psychogenic_sar_sched.sv
// Directed + randomized bench for psychogenic_sar_sched against a behavioural
// round-robin / binary-search reference model.
module tb_psychogenic_sar_sched;
  import psychogenic_sar_pkg::*;

  localparam int NREQ     = 4;
  localparam int NBITS    = 8;
  localparam int ACQ      = 4;
  localparam int SETTLE   = 3;
  localparam int DONE_CYC = ACQ + NBITS * (SETTLE + 1) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmp_in;
  logic       mux_en;
  logic [1:0] mux_sel;
  logic [7:0] dac_code;
  int         cmp_mode = 0;
  logic [7:0] tgt = 8'h00;
  int         n_assert = 0;
  int         n_fail = 0;
  int         m_last = NREQ - 1;
  int         g_ch;

  psychogenic_sar_sched_if #(.NREQ(NREQ), .NBITS(NBITS)) bus ();

  psychogenic_sar_sched #(.NREQ(NREQ), .NBITS(NBITS), .ACQ(ACQ), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mux_en   (mux_en),
    .mux_sel  (mux_sel),
    .dac_code (dac_code),
    .cmp_in   (cmp_in)
  );

  always #5 clk = ~clk;

  // Comparator: ideal analog input tgt, or tied high/low.
  assign cmp_in = (cmp_mode == 0) ? (tgt >= dac_code) : (cmp_mode == 1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int i = 1; i <= NREQ; i++)
      if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  // One conversion; current cycle is cycle 0 (IDLE sampling req).
  task automatic conv(input string tag, input logic [7:0] exp_res, input bit hold,
                      input int act_cyc, input logic [3:0] act_set,
                      input logic [3:0] act_clr, input bit act_rst, input bit chk_codes);
    int ch;
    int k;
    int first_code_cyc;
    bit seen;
    logic [7:0] prev;
    logic [7:0] part;
    logic [7:0] code;
    logic [7:0] codes[$];
    ch     = rr_pick(bus.req, m_last);
    m_last = ch;
    g_ch   = ch;
    prev   = dac_code;
    seen   = 1'b0;
    first_code_cyc = -1;
    for (k = 1; k <= DONE_CYC + 5; k++) begin
      step();
      if (dac_code !== prev && dac_code != 8'h00) begin
        codes.push_back(dac_code);
        if (first_code_cyc < 0) first_code_cyc = k;
      end
      prev = dac_code;
      if (k == 1) begin
        chk({tag, " mux_sel"}, mux_sel, ch);
        chk({tag, " mux_en/busy"}, {mux_en, bus.busy}, 2'b11);
      end
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (k == act_cyc) begin
        if (act_rst) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          chk({tag, " outputs after reset"},
              {bus.busy, bus.done, bus.ack, mux_en, mux_sel, dac_code, bus.result, bus.result_chan}, 0);
          m_last = NREQ - 1;
          return;
        end
        bus.req = (bus.req | act_set) & ~act_clr;
      end
    end
    chk({tag, " done cycle"}, seen ? k : -1, DONE_CYC);
    chk({tag, " result"}, bus.result, exp_res);
    chk({tag, " result_chan"}, bus.result_chan, ch);
    chk({tag, " ack"}, bus.ack, 4'b0001 << ch);
    if (!hold) bus.req[ch[1:0]] = 1'b0;
    step();
    chk({tag, " idle after done"}, {bus.done, bus.ack, bus.busy, mux_en, dac_code}, 0);
    if (chk_codes) begin
      chk({tag, " first code cycle"}, first_code_cyc, 1 + ACQ);
      chk({tag, " code count"}, codes.size(), NBITS);
      part = 8'h00;
      for (int b = NBITS - 1; b >= 0; b--) begin
        code = part | (8'h01 << b);
        if (codes.size() > 0) chk({tag, " trial code"}, codes.pop_front(), code);
        if (exp_res >= code) part = code;
      end
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    repeat (3) step();
    chk("reset outputs",
        {bus.busy, bus.done, bus.ack, mux_en, mux_sel, dac_code, bus.result, bus.result_chan}, 0);
    rst = 1'b0;

    cmp_mode = 0; tgt = 8'hA5; bus.req = 4'b0001;
    conv("basic", 8'hA5, 1'b0, 0, 4'b0, 4'b0, 1'b0, 1'b1);

    tgt = 8'h3C; bus.req = 4'b0001;
    conv("drop", 8'h3C, 1'b0, 5, 4'b0, 4'b0001, 1'b0, 1'b0);

    cmp_mode = 1; bus.req = 4'b0001;
    conv("tie1", 8'hFF, 1'b0, 0, 4'b0, 4'b0, 1'b0, 1'b1);
    cmp_mode = 2; bus.req = 4'b0001;
    conv("tie0", 8'h00, 1'b0, 0, 4'b0, 4'b0, 1'b0, 1'b0);

    cmp_mode = 0;
    repeat (4) begin
      tgt     = 8'($urandom);
      bus.req = bus.req | 4'($urandom_range(1, 15));
      conv("rand", tgt, 1'b0, 0, 4'b0, 4'b0, 1'b0, 1'b0);
    end

    rst = 1'b1; step(); rst = 1'b0; m_last = NREQ - 1;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tgt = 8'($urandom);
      conv("rr", tgt, 1'b1, 0, 4'b0, 4'b0, 1'b0, 1'b0);
      chk("rr order", g_ch, i % 4);
    end

    bus.req = 4'b0100;
    conv("late1", tgt, 1'b0, 10, 4'b0010, 4'b0, 1'b0, 1'b0);
    chk("late1 chan", g_ch, 2);
    conv("late2", tgt, 1'b0, 10, 4'b1000, 4'b0, 1'b0, 1'b0);
    chk("late2 chan", g_ch, 1);
    conv("late3", tgt, 1'b0, 0, 4'b0, 4'b0, 1'b0, 1'b0);
    chk("late3 chan", g_ch, 3);

    bus.req = 4'b0100;
    conv("rstmid", tgt, 1'b0, 20, 4'b0, 4'b0, 1'b1, 1'b0);
    bus.req = 4'b0011; tgt = 8'h5A;
    conv("post rst", 8'h5A, 1'b0, 0, 4'b0, 4'b0, 1'b0, 1'b0);
    chk("post rst prio", g_ch, 0);
    conv("post rst ch1", 8'h5A, 1'b0, 0, 4'b0, 4'b0, 1'b0, 1'b0);
    chk("post rst ch1 chan", g_ch, 1);

    bus.req = 4'b0000;
    repeat (3) step();
    chk("quiet idle", {bus.busy, bus.done, mux_en}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
